// File: rtl/dcache_wb_buffer_if.sv
// Cache-side push/lookup port and AXI write channels of the data-cache write-back buffer.
// The buffer takes the slave modport; the cache/interconnect side takes master.
interface dcache_wb_buffer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WORD_NUM = 4
);
  logic                                push_valid;
  logic                                push_ready;
  logic [31:0]                         push_addr;
  logic [LINE_WORD_NUM*DATA_WIDTH-1:0] push_line;
  logic [31:0]                         lookup_addr;
  logic                                lookup_hit;
  logic [LINE_WORD_NUM*DATA_WIDTH-1:0] lookup_line;
  logic                                empty;
  logic [31:0]                         awaddr;
  logic [7:0]                          awlen;
  logic [2:0]                          awsize;
  logic [1:0]                          awburst;
  logic                                awvalid;
  logic                                awready;
  logic [DATA_WIDTH-1:0]               wdata;
  logic [3:0]                          wstrb;
  logic                                wlast;
  logic                                wvalid;
  logic                                wready;
  logic                                bvalid;
  logic                                bready;

  modport slave (
    input  push_valid, push_addr, push_line, lookup_addr, awready, wready, bvalid,
    output push_ready, lookup_hit, lookup_line, empty,
           awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready
  );

  modport master (
    output push_valid, push_addr, push_line, lookup_addr, awready, wready, bvalid,
    input  push_ready, lookup_hit, lookup_line, empty,
           awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Victim buffer for dirty evicted cache lines: circular FIFO drained as AXI INCR bursts,
// with a combinational lookup so refills can be forwarded from lines still buffered.
module dcache_wb_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int LINE_WORD_NUM = 4,
  parameter int DEPTH         = 4
) (
  input logic               clk,
  input logic               reset,
  dcache_wb_buffer_if.slave bus
);
  localparam int LINE_WIDTH = LINE_WORD_NUM * DATA_WIDTH;
  localparam int OFFSET     = $clog2(LINE_WIDTH / 8);
  localparam int TAG_WIDTH  = 32 - OFFSET;
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int BEAT_WIDTH = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  logic [DEPTH-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] line_q [DEPTH];
  logic [PTR_WIDTH-1:0]  head_q;
  logic [PTR_WIDTH-1:0]  tail_q;
  logic [PTR_WIDTH:0]    count_q;
  state_t                state_q;
  logic [BEAT_WIDTH-1:0] beat_q;
  logic [BEAT_WIDTH-1:0] beat_next;
  logic                  push;
  logic                  pop;
  logic [LINE_WIDTH-1:0] head_line;
  logic                  awvalid_q;
  logic [31:0]           awaddr_q;
  logic                  wvalid_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic                  hit_c;
  logic [LINE_WIDTH-1:0] hit_line_c;
  logic [PTR_WIDTH-1:0]  idx_c;
  logic                  unused_offset_bits;

  assign bus.push_ready = count_q < (PTR_WIDTH+1)'(DEPTH);
  assign push           = bus.push_valid && bus.push_ready;
  assign pop            = bready_q && bus.bvalid;
  assign head_line      = line_q[head_q];
  assign beat_next      = beat_q + 1'b1;

  assign bus.empty   = (count_q == '0) && (state_q == IDLE);
  assign bus.awaddr  = awaddr_q;
  assign bus.awlen   = 8'(LINE_WORD_NUM - 1);
  assign bus.awsize  = 3'b010;
  assign bus.awburst = 2'b01;
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = 4'hF;
  assign bus.wlast   = wlast_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

  assign unused_offset_bits = ^{bus.push_addr[OFFSET-1:0], bus.lookup_addr[OFFSET-1:0]};

  // Entry payload carries no reset; only the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= bus.push_addr[31:OFFSET];
      line_q[tail_q] <= bus.push_line;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // The head entry is only released on its B handshake, so its line stays put for the whole burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q   <= AW;
            awvalid_q <= 1'b1;
            awaddr_q  <= {tag_q[head_q], {OFFSET{1'b0}}};
          end
        end
        AW: begin
          if (bus.awready) begin
            state_q   <= W;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            wdata_q   <= head_line[DATA_WIDTH-1:0];
            wlast_q   <= (LINE_WORD_NUM == 1);
          end
        end
        W: begin
          if (bus.wready) begin
            if (wlast_q) begin
              state_q  <= B;
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
            end else begin
              beat_q  <= beat_next;
              wdata_q <= head_line[int'(beat_next)*DATA_WIDTH +: DATA_WIDTH];
              wlast_q <= (beat_next == BEAT_WIDTH'(LINE_WORD_NUM - 1));
            end
          end
        end
        B: begin
          if (bus.bvalid) begin
            state_q  <= IDLE;
            bready_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest matching duplicate wins.
  always_comb begin
    hit_c      = 1'b0;
    hit_line_c = '0;
    idx_c      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx_c = head_q + PTR_WIDTH'(i);
      if (valid_q[idx_c] && (tag_q[idx_c] == bus.lookup_addr[31:OFFSET])) begin
        hit_c      = 1'b1;
        hit_line_c = line_q[idx_c];
      end
    end
  end

  assign bus.lookup_hit  = hit_c;
  assign bus.lookup_line = hit_line_c;
endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
- Write-back (victim) buffer that sits directly downstream of the data cache.
- Accepts dirty cache lines evicted on a miss and drains them to memory as AXI INCR write bursts.
- Lets the cache go straight from eviction to refill, with no blocking writeback state.
- Gives the cache a combinational address lookup, so a refill that targets a line still in the buffer is detected and forwarded.

Parameters:
- DATA_WIDTH, 32, width of one word and of the AXI W data bus.
- LINE_WORD_NUM, 4, words per cache line; this is also the burst length.
- DEPTH, 4, number of line entries (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- push_valid  in  1  cache offers a dirty line.
- push_ready  out  1  buffer can accept the line; asserted when count < DEPTH.
- push_addr  in  32  line-aligned physical address; offset bits are ignored and forced to 0.
- push_line  in  LINE_WORD_NUM*DATA_WIDTH  line data; word 0 is in the LSBs.
- lookup_addr  in  32  physical address probed by the cache on a miss.
- lookup_hit  out  1  some valid entry matches the line address.
- lookup_line  out  LINE_WORD_NUM*DATA_WIDTH  data of the matching entry; 0 when there is no hit.
- empty  out  1  no valid entries and no transaction outstanding.
- awaddr  out  32  burst address.
- awlen  out  8  constant LINE_WORD_NUM-1.
- awsize  out  3  constant 3'b010.
- awburst  out  2  constant 2'b01 (INCR).
- awvalid  out  1  AW channel valid.
- awready  in  1  AW channel ready.
- wdata  out  DATA_WIDTH  W channel data.
- wstrb  out  4  constant 4'hF.
- wlast  out  1  final beat of the burst.
- wvalid  out  1  W channel valid.
- wready  in  1  W channel ready.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.

Behaviour:
- Storage:
  - Circular FIFO of DEPTH entries; each entry holds {valid, line address [31:OFFSET], line}.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Push:
  - Occurs when push_valid && push_ready at a clock edge.
  - The entry is written at tail, valid is set, tail is incremented.
  - A duplicate address is legal and creates a new entry.
- Pop:
  - Occurs only on the B handshake of the head entry; that entry's valid clears and head increments.
  - Push and pop in the same cycle: count is unchanged and both take effect.
  - push_ready is computed from the registered count only; a same-cycle pop does not free a slot.
- Drain FSM (states IDLE, AW, W, B):
  - IDLE: if count != 0, go to AW next cycle; awaddr = head address with zero offset.
  - AW: hold awvalid=1 with awaddr stable until awready; on handshake go to W and set beat=0.
  - W: wvalid=1, wdata = head line word[beat], wlast = (beat == LINE_WORD_NUM-1).
    - Each wready handshake increments beat.
    - The wlast handshake moves to B.
    - wvalid is not issued before the AW handshake.
  - B: bready=1; on bvalid, pop and return to IDLE. bresp is ignored.
- Latency: minimum push-to-awvalid is 2 cycles (push edge, then IDLE to AW).
- Lookup (combinational):
  - Compare lookup_addr[31:OFFSET] against all valid entries.
  - On multiple matches, the youngest entry (closest to tail) drives lookup_line.
  - The head entry stays hittable until its B handshake completes.
  - A push in the current cycle is not visible to lookup until the next cycle.
- Empty: empty = (count == 0) && state == IDLE.
- Reset values:
  - Every output is 0, except push_ready=1, empty=1, and the constants awlen, awsize, awburst, wstrb.
  - All valid bits cleared, pointers and count = 0, state = IDLE.
- Reset mid-burst: the burst is abandoned and all entries are dropped. The interconnect is reset by the same signal.
- Full: push_valid is held by the cache; nothing is dropped and nothing is overwritten.

Test Plan:
- Single push, line 0x1FC0_0040 with words {0x11,0x22,0x33,0x44}, all readies=1:
  - Expect awaddr=0x1FC0_0040, awlen=3.
  - Expect 4 W beats 0x11..0x44 with wlast on beat 3.
  - After bvalid, empty=1.
- Push 4 lines with awready=0:
  - push_ready=0 after the 4th push.
  - A 5th push_valid is held off.
  - Release awready: lines drain in push order; push_ready returns 1 after the first B.
- Lookup 0x1FC0_004C while the line at 0x1FC0_0040 is buffered: lookup_hit=1 and lookup_line matches the pushed line. Lookup 0x1FC0_0080 gives hit=0 and line=0.
- Push 0x100 with data A, then 0x100 with data B, before draining: lookup_line=B. After the first B response, hit=1 with B. After the second, hit=0.
- Randomized wready/awready/bvalid stalls with simultaneous push and pop at count=2: count stays at 2, data order is preserved, awaddr is stable while awvalid && !awready.
- Assert reset during W beat 2 with 3 entries: next cycle all valids=0, empty=1, wvalid=0, push_ready=1.
